// File: rtl/q2.sv
// q2: 12-bit accumulator processor with a front-panel switch interface.
// Memory is external; dbus is driven by q2 only during a write cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | halted; abus=P, front-panel switches serviced
// S_FETCH  | read instruction at P into IR, P+=1
// S_DECODE | form EA; JMP (direct) and OPR complete here
// S_IND    | read mem[EA] into EA for indirect addressing
// S_READ   | read operand into MD; AND/ADD/LDA complete here
// S_WRITE  | one-cycle write of MD to mem[EA] (also front-panel deposit)
module q2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw,
  input  logic        incp_sw,
  input  logic        dep_sw,
  input  logic        start_sw,
  input  logic        stop_sw,
  output logic [11:0] abus,
  inout  wire  [11:0] dbus,
  output logic        rdm,
  output logic        wrm,
  output logic        run
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_IND    = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JSR = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  logic [2:0]  state;
  logic [11:0] a, p, ir, ea, md;
  logic        stop_pend;
  logic [3:0]  sw_samp, sw_prev, sw_edge;
  logic [2:0]  op;
  logic [11:0] ea_dir, ea_eff, a_opr, isz_val;
  logic        opr_skip, instr_done, halt_now, stop_now;

  // switch order in the edge vectors: {stop, start, dep, incp}
  assign sw_edge  = sw_samp & ~sw_prev;
  assign op       = ir[11:9];
  assign ea_dir   = {(ir[7] ? p[11:7] : 5'd0), ir[6:0]};
  assign ea_eff   = (state == S_IND) ? dbus : ea_dir;
  assign isz_val  = dbus + 12'd1;
  assign stop_now = stop_pend | (run & sw_edge[3]);
  assign halt_now = (state == S_DECODE) && (op == OP_OPR) && ir[0];

  assign abus = (state == S_IND || state == S_READ || state == S_WRITE) ? ea : p;
  assign rdm  = (state == S_FETCH) || (state == S_IND) || (state == S_READ);
  assign wrm  = (state == S_WRITE);
  assign dbus = wrm ? md : 12'bz;

  always_comb begin
    a_opr = a;
    if (ir[1]) a_opr = 12'd0;
    if (ir[2]) a_opr = ~a_opr;
    if (ir[3]) a_opr = a_opr + 12'd1;
    if (ir[4] && !ir[5])      a_opr = {1'b0, a_opr[11:1]};
    else if (ir[5] && !ir[4]) a_opr = {a_opr[10:0], 1'b0};
    opr_skip = (ir[6] && (a_opr == 12'd0)) || (ir[7] && a_opr[11]);
  end

  always_comb begin
    instr_done = 1'b0;
    case (state)
      S_DECODE: instr_done = (op == OP_OPR) || (!ir[8] && op == OP_JMP);
      S_IND:    instr_done = (op == OP_JMP);
      S_READ:   instr_done = (op != OP_ISZ);
      S_WRITE:  instr_done = run;
      default:  instr_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      a         <= 12'd0;
      p         <= 12'd0;
      ir        <= 12'd0;
      ea        <= 12'd0;
      md        <= 12'd0;
      run       <= 1'b0;
      stop_pend <= 1'b0;
      // history starts high so a switch held through reset must drop first
      sw_samp   <= 4'hF;
      sw_prev   <= 4'hF;
    end else begin
      sw_samp <= {stop_sw, start_sw, dep_sw, incp_sw};
      sw_prev <= sw_samp;
      if (run && sw_edge[3]) stop_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!sw_edge[3]) begin
            if (sw_edge[2]) begin
              run   <= 1'b1;
              state <= S_FETCH;
            end else if (sw_edge[1]) begin
              ea    <= p;
              md    <= sw;
              state <= S_WRITE;
            end else if (sw_edge[0]) begin
              p <= p + 12'd1;
            end
          end
        end
        S_FETCH: begin
          ir    <= dbus;
          p     <= p + 12'd1;
          state <= S_DECODE;
        end
        S_DECODE, S_IND: begin
          if (state == S_DECODE && op == OP_OPR) begin
            a <= a_opr;
            if (opr_skip) p <= p + 12'd1;
          end else if (state == S_DECODE && ir[8]) begin
            ea    <= ea_dir;
            state <= S_IND;
          end else begin
            ea <= ea_eff;
            case (op)
              OP_JMP: p <= ea_eff;
              OP_STA: begin
                md    <= a;
                state <= S_WRITE;
              end
              OP_JSR: begin
                md    <= p;
                p     <= ea_eff + 12'd1;
                state <= S_WRITE;
              end
              default: state <= S_READ;
            endcase
          end
        end
        S_READ: begin
          md <= dbus;
          case (op)
            OP_AND: a <= a & dbus;
            OP_ADD: a <= a + dbus;
            OP_LDA: a <= dbus;
            default: begin
              md    <= isz_val;
              state <= S_WRITE;
              if (isz_val == 12'd0) p <= p + 12'd1;
            end
          endcase
        end
        S_WRITE: begin
          if (!run) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (instr_done) begin
        if (halt_now || stop_now) begin
          state     <= S_IDLE;
          run       <= 1'b0;
          stop_pend <= 1'b0;
        end else begin
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_q2.sv
// Self-checking bench for q2: external memory, instruction-level reference
// model producing the expected bus trace, and front-panel/reset scenarios.
module tb_q2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sw = 12'h000;
  logic        incp_sw = 1'b0, dep_sw = 1'b0, start_sw = 1'b0, stop_sw = 1'b0;
  logic [11:0] abus;
  wire  [11:0] dbus;
  logic        rdm, wrm, run;

  q2 dut (
    .clk(clk), .rst(rst), .sw(sw),
    .incp_sw(incp_sw), .dep_sw(dep_sw), .start_sw(start_sw), .stop_sw(stop_sw),
    .abus(abus), .dbus(dbus), .rdm(rdm), .wrm(wrm), .run(run)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [4096];
  logic [11:0] mm  [4096];
  logic [11:0] m_a;
  logic [11:0] last_wa, last_wd;
  int checks = 0, errors = 0, wr_count = 0, run_cycles = 0;
  bit chk_en = 1'b0;

  assign dbus = rdm ? mem[abus] : 12'bz;

  always @(negedge clk) begin
    if (wrm) begin
      mem[abus] = dbus;
      last_wa   = abus;
      last_wd   = dbus;
      wr_count++;
    end
  end

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic [11:0] data;
  } bus_t;
  bus_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // kind: 0 = no access, 1 = read, 2 = write
  always @(negedge clk) begin : cmp_proc
    bus_t e;
    if (chk_en && run) begin
      run_cycles++;
      if (exp_q.size() == 0) begin
        chk("trace_overrun", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bus_cycle",
            {6'd0, rdm, wrm, (e.kind != 2'd0) ? abus : 12'h000, (e.kind == 2'd2) ? dbus : 12'h000},
            {6'd0, e.kind == 2'd1, e.kind == 2'd2, e.addr, e.data});
      end
    end
  end

  task automatic push(input logic [1:0] k, input logic [11:0] ad, input logic [11:0] d);
    exp_q.push_back({k, ad, d});
  endtask

  // Instruction-level interpreter from address 000 until HLT.
  task automatic model_run(output logic [11:0] p_end);
    logic [11:0] p, ir, ea, t;
    logic [2:0]  op;
    bit          halted;
    p = 12'h000;
    halted = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 200 && !halted; n++) begin
      ir = mm[p];
      push(2'd1, p, 12'h000);
      p = p + 12'd1;
      push(2'd0, 12'h000, 12'h000);
      op = ir[11:9];
      ea = {(ir[7] ? p[11:7] : 5'd0), ir[6:0]};
      if (op == 3'd7) begin
        if (ir[1]) m_a = 12'h000;
        if (ir[2]) m_a = ~m_a;
        if (ir[3]) m_a = m_a + 12'd1;
        if (ir[4] && !ir[5]) m_a = m_a >> 1;
        else if (ir[5] && !ir[4]) m_a = m_a << 1;
        if ((ir[6] && m_a == 12'h000) || (ir[7] && m_a[11])) p = p + 12'd1;
        if (ir[0]) halted = 1'b1;
      end else begin
        if (ir[8]) begin
          push(2'd1, ea, 12'h000);
          ea = mm[ea];
        end
        case (op)
          3'd0: begin push(2'd1, ea, 12'h000); m_a = m_a & mm[ea]; end
          3'd1: begin push(2'd1, ea, 12'h000); m_a = m_a + mm[ea]; end
          3'd2: begin push(2'd1, ea, 12'h000); m_a = mm[ea]; end
          3'd3: begin push(2'd2, ea, m_a); mm[ea] = m_a; end
          3'd4: p = ea;
          3'd5: begin push(2'd2, ea, p); mm[ea] = p; p = ea + 12'd1; end
          default: begin
            push(2'd1, ea, 12'h000);
            t = mm[ea] + 12'd1;
            push(2'd2, ea, t);
            mm[ea] = t;
            if (t == 12'h000) p = p + 12'd1;
          end
        endcase
      end
    end
    p_end = p;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 12'h000;
      mm[i]  = 12'h000;
    end
  endtask

  task automatic setm(input logic [11:0] ad, input logic [11:0] v);
    mem[ad] = v;
    mm[ad]  = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    m_a = 12'h000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // m = {stop, start, dep, incp}
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {stop_sw, start_sw, dep_sw, incp_sw} = m;
    @(negedge clk);
    {stop_sw, start_sw, dep_sw, incp_sw} = 4'b0000;
  endtask

  task automatic run_prog(input string name, output int cyc);
    logic [11:0] pend;
    int exp_cyc, diffs;
    model_run(pend);
    exp_cyc = exp_q.size();
    run_cycles = 0;
    chk_en = 1'b1;
    pulse(4'b0100);
    for (int i = 0; i < 10 && !run; i++) @(negedge clk);
    chk({name, "_started"}, {31'd0, run}, 32'd1);
    for (int i = 0; i < 3000 && run; i++) @(negedge clk);
    chk_en = 1'b0;
    chk({name, "_halted"}, {31'd0, run}, 32'd0);
    chk({name, "_trace_left"}, exp_q.size(), 32'd0);
    chk({name, "_cycles"}, run_cycles, exp_cyc);
    chk({name, "_halt_p"}, {20'd0, abus}, {20'd0, pend});
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== mm[i]) diffs++;
    chk({name, "_mem_image"}, diffs, 32'd0);
    cyc = run_cycles;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc, w0, w1;
    bit found;
    logic prev_rdm;

    clear_mem();
    m_a = 12'h000;
    start_sw = 1'b1;
    #2 rst = 1'b0;
    #1 chk("reset_outputs", {17'd0, run, rdm, wrm, abus}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {17'd0, run, rdm, wrm, abus}, 32'd0);
    end
    start_sw = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_no_edge", {31'd0, run}, 32'd0);

    // LDA, ADD, STA indirect into FFF, HLT
    clear_mem();
    setm(12'h000, 12'h410); setm(12'h001, 12'h211);
    setm(12'h002, 12'h712); setm(12'h003, 12'hE01);
    setm(12'h010, 12'h005); setm(12'h011, 12'h007); setm(12'h012, 12'hFFF);
    do_reset();
    w0 = wr_count;
    run_prog("basic", cyc);
    chk("basic_cycles_literal", cyc, 32'd12);
    chk("basic_fff", {20'd0, mem[12'hFFF]}, 32'h00C);
    chk("basic_ptr_kept", {20'd0, mem[12'h012]}, 32'hFFF);
    chk("basic_writes", wr_count - w0, 32'd1);

    // JSR
    clear_mem();
    setm(12'h000, 12'hA20); setm(12'h021, 12'hE01);
    do_reset();
    run_prog("jsr", cyc);
    chk("jsr_link", {20'd0, mem[12'h020]}, 32'h001);
    chk("jsr_halt_p", {20'd0, abus}, 32'h022);

    // ISZ wrap and skip
    clear_mem();
    setm(12'h010, 12'hFFF); setm(12'h000, 12'hC10);
    setm(12'h001, 12'hE01); setm(12'h002, 12'hE03);
    do_reset();
    run_prog("isz", cyc);
    chk("isz_mem", {20'd0, mem[12'h010]}, 32'h000);
    chk("isz_halt_p", {20'd0, abus}, 32'h003);

    // indirect LDA, AND, OPR micro-ops and skips, current-page ADD
    clear_mem();
    setm(12'h000, 12'h530); setm(12'h001, 12'h032); setm(12'h002, 12'hE0C);
    setm(12'h003, 12'hE80); setm(12'h004, 12'hE01); setm(12'h005, 12'hE10);
    setm(12'h006, 12'hE30); setm(12'h007, 12'hE40); setm(12'h008, 12'h633);
    setm(12'h009, 12'h934);
    setm(12'h030, 12'h031); setm(12'h031, 12'h0F3); setm(12'h032, 12'h0F0);
    setm(12'h034, 12'h0A0);
    setm(12'h0A0, 12'h2B0); setm(12'h0A1, 12'hE41); setm(12'h0B0, 12'h878);
    do_reset();
    run_prog("mixed", cyc);
    chk("mixed_sta", {20'd0, mem[12'h033]}, 32'h788);
    chk("mixed_halt_p", {20'd0, abus}, 32'h0A3);

    // front panel
    clear_mem();
    do_reset();
    sw = 12'h123;
    w0 = wr_count;
    pulse(4'b0010);
    repeat (3) @(negedge clk);
    chk("dep_pulses", wr_count - w0, 32'd1);
    chk("dep_addr", {20'd0, last_wa}, 32'h000);
    chk("dep_data", {20'd0, last_wd}, 32'h123);
    chk("dep_mem", {20'd0, mem[12'h000]}, 32'h123);
    chk("dep_p_kept", {20'd0, abus}, 32'h000);
    pulse(4'b0001);
    repeat (2) @(negedge clk);
    chk("incp_p", {20'd0, abus}, 32'h001);
    sw = 12'h456;
    w0 = wr_count;
    pulse(4'b0011);
    repeat (3) @(negedge clk);
    chk("dep_over_incp_wr", wr_count - w0, 32'd1);
    chk("dep_over_incp_p", {20'd0, abus}, 32'h001);
    chk("dep_over_incp_mem", {20'd0, mem[12'h001]}, 32'h456);
    pulse(4'b1100);
    repeat (3) @(negedge clk);
    chk("stop_over_start", {31'd0, run}, 32'd0);
    repeat (4094) pulse(4'b0001);
    repeat (2) @(negedge clk);
    chk("incp_fff", {20'd0, abus}, 32'hFFF);
    pulse(4'b0001);
    repeat (2) @(negedge clk);
    chk("incp_wrap", {20'd0, abus}, 32'h000);

    // stop while looping on JMP 000
    clear_mem();
    setm(12'h000, 12'h800);
    do_reset();
    pulse(4'b0100);
    repeat (20) @(negedge clk);
    chk("loop_running", {31'd0, run}, 32'd1);
    pulse(4'b1000);
    prev_rdm = 1'b1;
    for (int i = 0; i < 20 && run; i++) begin
      prev_rdm = rdm;
      @(negedge clk);
    end
    chk("stop_halt", {31'd0, run}, 32'd0);
    chk("stop_boundary", {31'd0, prev_rdm}, 32'd0);
    chk("stop_p", {20'd0, abus}, 32'h000);
    repeat (5) @(negedge clk);
    chk("stop_stays_idle", {30'd0, run, rdm}, 32'd0);

    // reset in the STA write cycle
    clear_mem();
    setm(12'h000, 12'h610);
    do_reset();
    pulse(4'b0100);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (wrm) begin
        found = 1'b1;
        break;
      end
    end
    chk("sta_write_seen", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1 chk("rst_mid_write", {17'd0, run, rdm, wrm, abus}, 32'd0);
    w1 = wr_count;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_after_mid_rst", {17'd0, run, rdm, wrm, abus}, 32'd0);
    end
    chk("no_write_after_rst", wr_count - w1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
